// File: rtl/calc_pkg.sv
// Shared constants for the calculator ALU sequencer: opcodes, ALU selector
// codes, FSM state encoding and a helper that maps simple ops to selectors.
package calc_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_DIV = 3'd5;

    // Selector bit 2 tells the ALU to negate num2.
    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_OR   = 3'b010;
    localparam logic [2:0] SEL_AND  = 3'b011;
    localparam logic [2:0] SEL_SUB  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [2:0] op_to_sel(input logic [2:0] op);
        case (op)
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            OP_ADD:  return SEL_ADD;
            OP_SUB:  return SEL_SUB;
            default: return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between entry logic and the ALU sequencer.
interface alu_sequencer_if
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_ovf;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_err
    );

endinterface

// File: rtl/alu_seq_datapath.sv
// Iteration registers for shift-add MUL and repeated-subtract DIV, plus the
// latched operands and the MUL overflow sticky.
module alu_seq_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mul_step,
    input  logic             div_step,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] acc_q,
    output logic [WIDTH-1:0] mcand_q,
    output logic             mplier_lsb,
    output logic [WIDTH-1:0] rem_q,
    output logic [WIDTH-1:0] quo_q,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             ovf_nxt,
    output logic             mul_last,
    output logic             rem_ge_b
);

    localparam int STEP_W = $clog2(MUL_STEPS + 1);

    logic [WIDTH-1:0]  a_d, b_d, acc_d, mcand_d, mplier_d, mplier_q, rem_d, quo_d;
    logic              sticky_d, sticky_q;
    logic [STEP_W-1:0] step_d, step_q;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        sticky_d = sticky_q;
        step_d   = step_q;
        if (load) begin
            a_d      = a_in;
            b_d      = b_in;
            acc_d    = '0;
            mcand_d  = a_in;
            mplier_d = b_in;
            rem_d    = a_in;
            quo_d    = '0;
            sticky_d = 1'b0;
            step_d   = '0;
        end else if (mul_step) begin
            if (mplier_q[0]) begin
                acc_d = alu_y;
                if (alu_y < acc_q) sticky_d = 1'b1;
            end
            // A set bit leaving mcand only matters if later mplier bits would add it.
            if (mcand_q[WIDTH-1] && (mplier_q[WIDTH-1:1] != '0)) sticky_d = 1'b1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + STEP_W'(1);
        end else if (div_step) begin
            rem_d = alu_y;
            quo_d = quo_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            step_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            step_q   <= step_d;
        end
        a_q      <= a_d;
        b_q      <= b_d;
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
    end

    assign mplier_lsb = mplier_q[0];
    assign acc_nxt    = acc_d;
    assign ovf_nxt    = sticky_d;
    assign mul_last   = (step_q == STEP_W'(MUL_STEPS - 1));
    assign rem_ge_b   = (rem_q >= b_q);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared calculator ALU: sequences single ALU
// ops, shift-add MUL and repeated-subtract DIV, and returns result/status.
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    alu_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d, err_q, err_d;

    logic             accept, mul_step, div_step;
    logic [WIDTH-1:0] dp_a, dp_b, dp_acc, dp_mcand, dp_rem, dp_quo, dp_acc_nxt;
    logic             dp_mplier_lsb, dp_ovf_nxt, dp_mul_last, dp_rem_ge_b;

    assign accept   = bus.req_valid && (state_q == ST_IDLE);
    assign mul_step = (state_q == ST_MUL);
    assign div_step = (state_q == ST_DIV) && dp_rem_ge_b;

    alu_seq_datapath #(.WIDTH(WIDTH), .MUL_STEPS(MUL_STEPS)) u_dp (
        .clk(clk), .reset(reset), .load(accept),
        .a_in(bus.req_a), .b_in(bus.req_b),
        .mul_step(mul_step), .div_step(div_step), .alu_y(alu_y),
        .a_q(dp_a), .b_q(dp_b), .acc_q(dp_acc), .mcand_q(dp_mcand),
        .mplier_lsb(dp_mplier_lsb), .rem_q(dp_rem), .quo_q(dp_quo),
        .acc_nxt(dp_acc_nxt), .ovf_nxt(dp_ovf_nxt),
        .mul_last(dp_mul_last), .rem_ge_b(dp_rem_ge_b)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    case (bus.req_op)
                        OP_AND, OP_OR, OP_ADD, OP_SUB: state_d = ST_EXEC;
                        OP_MUL:  state_d = ST_MUL;
                        OP_DIV: begin
                            if (bus.req_b == '0) begin
                                state_d = ST_DONE;
                                err_d   = 1'b1;
                            end else begin
                                state_d = ST_DIV;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                result_d = alu_y;
                if (op_q == OP_ADD) ovf_d = (alu_y < dp_a);
                else if (op_q == OP_SUB) ovf_d = (dp_a < dp_b);
                state_d = ST_DONE;
            end
            ST_MUL: begin
                if (dp_mul_last) begin
                    result_d = dp_acc_nxt;
                    ovf_d    = dp_ovf_nxt;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                if (!dp_rem_ge_b) begin
                    result_d = dp_quo;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU ports decode purely from registered state, never from req_*.
    always_comb begin
        alu_num1 = '0;
        alu_num2 = '0;
        alu_sel  = SEL_ZERO;
        case (state_q)
            ST_EXEC: begin
                alu_num1 = dp_a;
                alu_num2 = dp_b;
                alu_sel  = op_to_sel(op_q);
            end
            ST_MUL: begin
                if (dp_mplier_lsb) begin
                    alu_num1 = dp_acc;
                    alu_num2 = dp_mcand;
                    alu_sel  = SEL_ADD;
                end
            end
            ST_DIV: begin
                if (dp_rem_ge_b) begin
                    alu_num1 = dp_rem;
                    alu_num2 = dp_b;
                    alu_sel  = SEL_SUB;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the shared ALU.
module tb_alu_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_num1, alu_num2, alu_y, n2;
    logic [2:0] alu_sel;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    alu_sequencer_if #(.WIDTH(8)) bus ();

    alu_sequencer #(.WIDTH(8), .MUL_STEPS(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_sel(alu_sel), .alu_y(alu_y)
    );

    always #5 clk = ~clk;

    always_comb begin
        n2 = alu_sel[2] ? (~alu_num2 + 8'd1) : alu_num2;
        case (alu_sel[1:0])
            2'b01:   alu_y = alu_num1 + n2;
            2'b10:   alu_y = alu_num1 | n2;
            2'b11:   alu_y = alu_num1 & n2;
            default: alu_y = 8'd0;
        endcase
    end

    task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Entered at the negedge just after the accept edge; cycles counts edges from accept.
    task automatic wait_rsp(input int max, output int cycles, output int subs);
        cycles = 1;
        subs   = 0;
        while (!bus.rsp_valid && cycles < max) begin
            if (alu_sel == SEL_SUB) subs++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL reset_hs ready=%b valid=%b required 1/0", bus.req_ready, bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if ({bus.rsp_result, bus.rsp_ovf, bus.rsp_err} !== 10'd0) $display("FAIL reset_rsp result=%0d ovf=%b err=%b required 0/0/0", bus.rsp_result, bus.rsp_ovf, bus.rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (alu_num1 !== 8'd0 || alu_num2 !== 8'd0 || alu_sel !== SEL_ZERO) $display("FAIL reset_alu num1=%0d num2=%0d sel=%b required 0/0/000", alu_num1, alu_num2, alu_sel);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_simple(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] exp_sel, input logic [7:0] exp_res, input logic exp_ovf);
        int cyc, subs;
        do_req(op, a, b);
        total_cnt++;
        if (alu_sel !== exp_sel || alu_num1 !== a || alu_num2 !== b) $display("FAIL %s_exec sel=%b n1=%0d n2=%0d required %b/%0d/%0d", name, alu_sel, alu_num1, alu_num2, exp_sel, a, b);
        else pass_cnt++;
        wait_rsp(20, cyc, subs);
        total_cnt++;
        if (cyc !== 2 || bus.rsp_valid !== 1'b1) $display("FAIL %s_lat latency=%0d valid=%b required 2/1", name, cyc, bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_result !== exp_res || bus.rsp_ovf !== exp_ovf || bus.rsp_err !== 1'b0) $display("FAIL %s_rsp result=%0d ovf=%b err=%b required %0d/%b/0", name, bus.rsp_result, bus.rsp_ovf, bus.rsp_err, exp_res, exp_ovf);
        else pass_cnt++;
        consume();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL %s_release valid=%b ready=%b required 0/1", name, bus.rsp_valid, bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_multi(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int exp_lat, input int exp_subs, input logic [7:0] exp_res, input logic exp_ovf, input logic exp_err);
        int cyc, subs;
        do_req(op, a, b);
        wait_rsp(40, cyc, subs);
        total_cnt++;
        if (cyc !== exp_lat || bus.rsp_valid !== 1'b1) $display("FAIL %s_lat latency=%0d valid=%b required %0d/1", name, cyc, bus.rsp_valid, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_result !== exp_res || bus.rsp_ovf !== exp_ovf || bus.rsp_err !== exp_err) $display("FAIL %s_rsp result=%0d ovf=%b err=%b required %0d/%b/%b", name, bus.rsp_result, bus.rsp_ovf, bus.rsp_err, exp_res, exp_ovf, exp_err);
        else pass_cnt++;
        if (op == OP_DIV) begin
            total_cnt++;
            if (subs !== exp_subs) $display("FAIL %s_subs sub_cycles=%0d required %0d", name, subs, exp_subs);
            else pass_cnt++;
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc, subs;
        do_req(OP_ADD, 8'd1, 8'd2);
        wait_rsp(20, cyc, subs);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_OR;
        bus.req_a     = 8'h0F;
        bus.req_b     = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd3 || bus.req_ready !== 1'b0 || alu_sel !== SEL_ZERO)
                $display("FAIL hold_%0d valid=%b result=%0d ready=%b sel=%b required 1/3/0/000", i, bus.rsp_valid, bus.rsp_result, bus.req_ready, alu_sel);
            else pass_cnt++;
        end
        consume();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL hold_release valid=%b ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        total_cnt++;
        if (bus.req_ready !== 1'b0 || alu_sel !== SEL_OR) $display("FAIL hold_accept ready=%b sel=%b required 0/010", bus.req_ready, alu_sel);
        else pass_cnt++;
        wait_rsp(20, cyc, subs);
        total_cnt++;
        if (cyc !== 2 || bus.rsp_result !== 8'hFF || bus.rsp_ovf !== 1'b0) $display("FAIL hold_second latency=%0d result=%0d ovf=%b required 2/255/0", cyc, bus.rsp_result, bus.rsp_ovf);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        do_req(OP_MUL, 8'd12, 8'd11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || {bus.rsp_result, bus.rsp_ovf, bus.rsp_err} !== 10'd0)
            $display("FAIL midreset_rsp ready=%b valid=%b result=%0d ovf=%b err=%b required 1/0/0/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, bus.rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (alu_num1 !== 8'd0 || alu_num2 !== 8'd0 || alu_sel !== SEL_ZERO) $display("FAIL midreset_alu num1=%0d num2=%0d sel=%b required 0/0/000", alu_num1, alu_num2, alu_sel);
        else pass_cnt++;
        reset = 1'b0;
        test_simple("and_after_reset", OP_AND, 8'hF0, 8'h3C, SEL_AND, 8'h30, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 8'd0;
        bus.req_b     = 8'd0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        test_reset();
        test_simple("add", OP_ADD, 8'd200, 8'd100, SEL_ADD, 8'd44, 1'b1);
        test_simple("sub", OP_SUB, 8'd5, 8'd9, SEL_SUB, 8'd252, 1'b1);
        test_simple("or", OP_OR, 8'hA0, 8'h05, SEL_OR, 8'hA5, 1'b0);
        test_multi("mul_12x11", OP_MUL, 8'd12, 8'd11, 9, 0, 8'd132, 1'b0, 1'b0);
        test_multi("mul_16x16", OP_MUL, 8'd16, 8'd16, 9, 0, 8'd0, 1'b1, 1'b0);
        test_multi("mul_255x1", OP_MUL, 8'd255, 8'd1, 9, 0, 8'd255, 1'b0, 1'b0);
        test_multi("div_100_7", OP_DIV, 8'd100, 8'd7, 16, 14, 8'd14, 1'b0, 1'b0);
        test_multi("div_3_9", OP_DIV, 8'd3, 8'd9, 2, 0, 8'd0, 1'b0, 1'b0);
        test_multi("div_by_zero", OP_DIV, 8'd50, 8'd0, 1, 0, 8'd0, 1'b0, 1'b1);
        test_multi("illegal_op7", 3'd7, 8'd1, 8'd2, 1, 0, 8'd0, 1'b0, 1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle operation controller for the calculator's shared 8-bit ALU (AND/OR/ADD/SUB datapath with two's-complement negate on operand 2).
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU's num1/num2/selector ports from registers.
- Captures the ALU result and builds MUL (shift-add) and DIV (repeated subtract) from single ALU additions/subtractions.
- Returns the result and status flags over a valid/ready response channel; sits between keypad/entry logic and the display formatter.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU data width.
- MUL_STEPS, 8, shift-add iterations for MUL; equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; the single clock is clk.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6–7 illegal.
- req_a  in  WIDTH  operand A (unsigned).
- req_b  in  WIDTH  operand B (unsigned).
- alu_num1  out  WIDTH  to ALU num1.
- alu_num2  out  WIDTH  to ALU num2.
- alu_sel  out  3  to ALU selector.
- alu_y  in  WIDTH  ALU result (combinational from alu_* outputs).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  result.
- rsp_ovf  out  1  ADD carry-out, SUB borrow, or MUL product > 255.
- rsp_err  out  1  DIV by zero or illegal op.

Behaviour:
- ALU selector encoding is fixed: ZERO 3'b000, ADD 3'b001, OR 3'b010, AND 3'b011, SUB 3'b101.
- Bit 2 of the selector negates num2.
- alu_* outputs are driven only from registered state; there is no combinational path from req_* to alu_*.
- In IDLE and DONE, alu_* outputs are 0 and alu_sel is ZERO.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_ovf 0, rsp_err 0, alu_num1 0, alu_num2 0, alu_sel ZERO.
- The request is accepted on an edge where req_valid and req_ready are both high. On that edge, op, A and B are latched.
- States: IDLE, EXEC, MUL, DIV, DONE.
- IDLE → EXEC for ops 0–3.
- IDLE → MUL for op 4.
- IDLE → DIV for op 5 with B ≠ 0.
- IDLE → DONE for DIV with B = 0, and for ops 6–7. In both cases rsp_err is set and rsp_result is 0.
- EXEC (1 cycle): drive A, B and the op's selector, then capture alu_y.
- ADD: rsp_ovf = (alu_y < A).
- SUB: rsp_ovf = (A < B).
- Go to DONE.
- MUL (exactly MUL_STEPS cycles):
  - acc starts at 0, mcand = A, mplier = B.
  - Each cycle: if mplier[0], drive ADD(acc, mcand) and acc <= alu_y; set the ovf sticky on carry (alu_y < acc).
  - Then mcand <<= 1 and mplier >>= 1.
  - Set the ovf sticky if a 1 shifts out of mcand while the remaining mplier ≠ 0.
  - If mplier[0] = 0, drive ZERO and do not update acc.
  - Result = product[7:0].
- DIV (quotient + 1 cycles):
  - rem starts at A, quo at 0.
  - Each cycle: if rem >= B (local unsigned compare), drive SUB(rem, B), rem <= alu_y, quo++.
  - Otherwise go to DONE with rsp_result = quo; rem is discarded.
- DONE: rsp_valid = 1.
  - rsp_result, rsp_ovf and rsp_err stay stable until an edge with rsp_ready = 1, then go to IDLE.
  - rsp_valid clears on that same edge.
  - req_ready is 0 throughout DONE; no request/response overlap.
- Latency (accept edge to first rsp_valid cycle):
  - ops 0–3: 2 edges.
  - MUL: 9 edges.
  - DIV: quotient + 2 edges.
  - error: 1 edge.
- Reset asserted in any state aborts the operation within that edge: all outputs return to reset values and the in-flight response is lost.
- req_* changes while not ready are ignored.
- rsp_ready while rsp_valid = 0 is ignored.

Decomposition:
- calc_pkg holds:
  - opcode constants OP_AND..OP_DIV;
  - ALU selector constants SEL_ZERO/ADD/OR/AND/SUB;
  - the state encoding;
  - WIDTH default.
- The ALU is instantiated outside the sequencer.
- Single natural sub-module: alu_seq_datapath, holding the acc/mcand/mplier/rem/quo registers and the ovf sticky. The FSM stays in the top.

Test Plan:
- ADD A=200, B=100 → rsp_result 44, rsp_ovf 1, rsp_err 0, rsp_valid 2 edges after accept. SUB A=5, B=9 → rsp_result 252, rsp_ovf 1.
- MUL A=12, B=11 → 132, ovf 0, latency 9 edges. MUL A=16, B=16 → 0, ovf 1. MUL A=255, B=1 → 255, ovf 0.
- DIV A=100, B=7 → 14, latency 16 edges; alu_sel = SUB on exactly 14 cycles. DIV A=3, B=9 → 0 after 2 edges.
- DIV A=50, B=0 → rsp_err 1, rsp_result 0 one edge after accept. Op 7 → rsp_err 1.
- Hold rsp_ready = 0 for 5 cycles with req_valid held high → response stable, req_ready 0, no second accept. Accept occurs on the edge after rsp_ready pulses.
- Assert reset at MUL cycle 4 → next cycle all outputs at reset values, req_ready 1. A new AND 0xF0 & 0x3C afterwards → 0x30.
